// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM burst arbiter: FSM state encoding and the
// response pipeline entry that travels alongside the ROM read latency.
package rom_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Wide enough for any practical requester count; the top truncates to IDW.
    localparam int PIPE_IDW = 8;

    typedef struct packed {
        logic                valid;
        logic [PIPE_IDW-1:0] id;
        logic                last;
    } pipe_t;

    localparam pipe_t PIPE_EMPTY = '{valid: 1'b0, id: '0, last: 1'b0};

endpackage

// File: rtl/rom_burst_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around to index 0.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        // First pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any       = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i]) begin
                any       = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin sharing of one 1-cycle-latency synchronous ROM between N_REQ
// burst requesters; returns tagged read data in issue order.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDRW = $clog2(DEPTH),
    parameter int LENW  = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*ADDRW-1:0] req_addr,
    input  logic [N_REQ*LENW-1:0]  req_len,
    output logic [N_REQ-1:0]       req_ready,
    output logic [ADDRW-1:0]       rom_addr,
    input  logic [WIDTH-1:0]       rom_data,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_last,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [LENW-1:0]  cnt_q, cnt_d;
    logic [LENW-1:0]  cnt_nxt;
    logic [ADDRW-1:0] addr_q, addr_d;
    pipe_t            s1_q, s1_d;
    pipe_t            s2_q, s2_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic [ADDRW-1:0] win_addr;
    logic [LENW-1:0]  win_len;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_picker (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[i*ADDRW +: ADDRW];
                win_len  = req_len[i*LENW +: LENW];
            end
        end
    end

    assign cnt_nxt = cnt_q + LENW'(1);

    // Word 0 is issued on the accept edge; cnt_q holds the index of the most
    // recently issued word. The BURST cycle that finds cnt_q==len_q issues
    // nothing, which is the single address bubble between bursts.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        s1_d    = PIPE_EMPTY;
        s2_d    = s1_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = BURST;
                    id_d    = grant_idx;
                    len_d   = win_len;
                    cnt_d   = '0;
                    addr_d  = win_addr;
                    ptr_d   = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDW'(1);
                    s1_d    = '{valid: 1'b1, id: PIPE_IDW'(grant_idx), last: (win_len == '0)};
                end
            end
            BURST: begin
                if (cnt_q != len_q) begin
                    cnt_d  = cnt_nxt;
                    addr_d = addr_q + ADDRW'(1);
                    s1_d   = '{valid: 1'b1, id: PIPE_IDW'(id_q), last: (cnt_nxt == len_q)};
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            s1_q    <= PIPE_EMPTY;
            s2_q    <= PIPE_EMPTY;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign rom_addr  = addr_q;
    assign rsp_valid = s2_q.valid;
    assign rsp_id    = IDW'(s2_q.id);
    assign rsp_last  = s2_q.last;
    assign rsp_data  = rom_data;
    assign busy      = (state_q == BURST) | s1_q.valid | s2_q.valid;

endmodule
